// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button front end for the TP1 ALU board.
// Each button lane has a two-flop synchroniser, a debounce FSM and a
// single-cycle press pulse. The lanes are independent.
// Optional feature: define BTN_AUTOREPEAT_EN for auto-repeat pulses while a
// button is held. Without it, each accepted press gives exactly one pulse.
module btn_conditioner #(
    parameter int NB_BTN          = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 50_000_000,
    parameter int NB_CNT          = 26
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_pulse,
    output logic [NB_BTN-1:0] o_level
);

    typedef enum logic [1:0] {
        Released,
        PressChk,
        Pressed,
        ReleaseChk
    } lane_state_t;

    localparam logic [NB_CNT-1:0] DebLast = NB_CNT'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [NB_CNT-1:0] RptLast = NB_CNT'(REPEAT_CYCLES - 1);
`else
    // The repeat period only matters when auto-repeat is built in.
    logic unused_repeat_cycles;
    assign unused_repeat_cycles = ^(NB_CNT'(REPEAT_CYCLES));
`endif

    logic [NB_BTN-1:0] sync_meta;
    logic [NB_BTN-1:0] sync;

    // Two-flop synchroniser. The FSMs look only at the second stage.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= i_btn;
            sync      <= sync_meta;
        end
    end

    for (genvar g = 0; g < NB_BTN; g++) begin : g_lane
        lane_state_t       state;
        logic [NB_CNT-1:0] cnt;
        logic              pulse;
        logic              level;
`ifdef BTN_AUTOREPEAT_EN
        logic [NB_CNT-1:0] rpt_cnt;
`endif

        // Debounce FSM. State, counters and both outputs update together.
        always_ff @(posedge clk or negedge i_reset) begin
            if (!i_reset) begin
                state <= Released;
                cnt   <= '0;
                pulse <= 1'b0;
                level <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rpt_cnt <= '0;
`endif
            end else begin
                pulse <= 1'b0;
                case (state)
                    Released: begin
                        if (sync[g]) begin
                            state <= PressChk;
                            cnt   <= '0;
                        end
                    end
                    PressChk: begin
                        if (!sync[g]) begin
                            // Bounce: drop the check and start over.
                            state <= Released;
                            cnt   <= '0;
                        end else if (cnt == DebLast) begin
                            state <= Pressed;
                            cnt   <= '0;
                            pulse <= 1'b1;
                            level <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    Pressed: begin
                        if (!sync[g]) begin
                            state <= ReleaseChk;
                            cnt   <= '0;
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (rpt_cnt == RptLast) begin
                            rpt_cnt <= '0;
                            pulse   <= 1'b1;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
`endif
                    end
                    ReleaseChk: begin
                        if (sync[g]) begin
                            // Release glitch. The repeat count stays frozen
                            // across it, and no new pulse is produced.
                            state <= Pressed;
                            cnt   <= '0;
                        end else if (cnt == DebLast) begin
                            state <= Released;
                            cnt   <= '0;
                            level <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= Released;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end

        assign o_pulse[g] = pulse;
        assign o_level[g] = level;
    end

endmodule
